// File: rtl/harmonic_accumulator_pkg.sv
// Shared types, default widths and the output saturation helper for the
// harmonic accumulator slice.
package harmonic_accumulator_pkg;

    localparam int DIV_BIT    = 8;
    localparam int SAMPLE_BIT = 16;
    localparam int OUT_BIT    = 16;
    localparam int HARM_BIT   = 7;
    localparam int ACC_BIT    = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESTART = 3'd1,
        ST_REQ     = 3'd2,
        ST_GAP     = 3'd3,
        ST_WAIT    = 3'd4,
        ST_MAC     = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

    // Clamp a sign-extended value into the signed range of an out_bit-wide word.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                    input int out_bit);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        logic signed [63:0] res;
        max_v = (64'sd1 <<< (out_bit - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_bit - 1));
        if (value > max_v) begin
            res = max_v;
        end else if (value < min_v) begin
            res = min_v;
        end else begin
            res = value;
        end
        return res;
    endfunction

endpackage

// File: rtl/harmonic_accumulator_if.sv
// Handshake bundle between the harmonic accumulator and its neighbours:
// sample control, scale multiplier, wavetable lookup and output stage.
interface harmonic_accumulator_if #(
    parameter int DIV_BIT    = 8,
    parameter int SAMPLE_BIT = 16,
    parameter int OUT_BIT    = 16,
    parameter int HARM_BIT   = 7
);
    logic                  i_Sample_Start;
    logic [HARM_BIT-1:0]   i_Harmonic_Count;
    logic                  o_Scale_Restart;
    logic                  o_Scale_Start;
    logic [DIV_BIT-1:0]    i_Mult;
    logic                  i_Mult_Ready;
    logic                  o_Sine_Req;
    logic [HARM_BIT-1:0]   o_Harmonic;
    logic [SAMPLE_BIT-1:0] i_Sine;
    logic                  i_Sine_Valid;
    logic [OUT_BIT-1:0]    o_Sample;
    logic                  o_Sample_Valid;
    logic                  o_Busy;
    logic                  o_Overrun;

    modport slave (
        input  i_Sample_Start, i_Harmonic_Count, i_Mult, i_Mult_Ready, i_Sine, i_Sine_Valid,
        output o_Scale_Restart, o_Scale_Start, o_Sine_Req, o_Harmonic,
               o_Sample, o_Sample_Valid, o_Busy, o_Overrun
    );

    modport master (
        output i_Sample_Start, i_Harmonic_Count, i_Mult, i_Mult_Ready, i_Sine, i_Sine_Valid,
        input  o_Scale_Restart, o_Scale_Start, o_Sine_Req, o_Harmonic,
               o_Sample, o_Sample_Valid, o_Busy, o_Overrun
    );
endinterface

// File: rtl/harmonic_accumulator_mac.sv
// Signed x unsigned multiply-accumulate with a floor-shifted, saturated
// output register that is loaded from the post-update accumulator value.
module harmonic_mac #(
    parameter int DIV_BIT    = 8,
    parameter int SAMPLE_BIT = 16,
    parameter int OUT_BIT    = 16,
    parameter int ACC_BIT    = 32
) (
    input  logic                         i_Clock,
    input  logic                         i_Reset_N,
    input  logic                         i_Clear,
    input  logic                         i_Enable,
    input  logic                         i_Load,
    input  logic signed [SAMPLE_BIT-1:0] i_Sine,
    input  logic        [DIV_BIT-1:0]    i_Mult,
    output logic signed [OUT_BIT-1:0]    o_Sample
);
    import harmonic_accumulator_pkg::*;

    logic signed [ACC_BIT-1:0] acc_q, acc_d;
    logic signed [ACC_BIT-1:0] sine_ext_s, mult_ext_s, shifted_s;
    logic signed [63:0]        sat_s;
    logic signed [OUT_BIT-1:0] sample_q, sample_d;

    // Next accumulator and output value; the output sees this cycle's partial.
    always_comb begin
        sine_ext_s = ACC_BIT'(i_Sine);
        mult_ext_s = ACC_BIT'({1'b0, i_Mult});
        if (i_Clear) begin
            acc_d = '0;
        end else if (i_Enable) begin
            acc_d = acc_q + sine_ext_s * mult_ext_s;
        end else begin
            acc_d = acc_q;
        end
        shifted_s = acc_d >>> DIV_BIT;
        sat_s     = saturate(64'(shifted_s), OUT_BIT);
        if (i_Load) begin
            sample_d = OUT_BIT'(sat_s);
        end else begin
            sample_d = sample_q;
        end
    end

    // Accumulator and held output sample.
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            acc_q    <= '0;
            sample_q <= '0;
        end else begin
            acc_q    <= acc_d;
            sample_q <= sample_d;
        end
    end

    assign o_Sample = sample_q;

endmodule

// File: rtl/harmonic_accumulator.sv
// Sequences one output sample: requests a multiple and a sine value per
// harmonic, accumulates the partials and emits the saturated result.
module harmonic_accumulator #(
    parameter int DIV_BIT    = harmonic_accumulator_pkg::DIV_BIT,
    parameter int SAMPLE_BIT = harmonic_accumulator_pkg::SAMPLE_BIT,
    parameter int OUT_BIT    = harmonic_accumulator_pkg::OUT_BIT,
    parameter int HARM_BIT   = harmonic_accumulator_pkg::HARM_BIT,
    parameter int ACC_BIT    = harmonic_accumulator_pkg::ACC_BIT
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset_N,
    harmonic_accumulator_if.slave  bus
);
    import harmonic_accumulator_pkg::*;

    state_e                state_q, state_d;
    logic [HARM_BIT-1:0]   count_q, count_d;
    logic [HARM_BIT-1:0]   index_q, index_d;
    logic [SAMPLE_BIT-1:0] sine_q, sine_d;
    logic [DIV_BIT-1:0]    mult_q, mult_d;
    logic                  sine_flag_q, sine_flag_d;
    logic                  mult_flag_q, mult_flag_d;
    logic                  scale_restart_q, scale_restart_d;
    logic                  scale_start_q, scale_start_d;
    logic                  sine_req_q, sine_req_d;
    logic                  sample_valid_q, sample_valid_d;
    logic                  busy_q, busy_d;
    logic                  overrun_q, overrun_d;
    logic                  acc_clear_s, acc_en_s, out_load_s;
    logic [OUT_BIT-1:0]    sample_s;

    // Sequencer next state; outputs are computed for the state being entered.
    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        index_d         = index_q;
        sine_d          = sine_q;
        mult_d          = mult_q;
        sine_flag_d     = sine_flag_q;
        mult_flag_d     = mult_flag_q;
        busy_d          = busy_q;
        scale_restart_d = 1'b0;
        scale_start_d   = 1'b0;
        sine_req_d      = 1'b0;
        sample_valid_d  = 1'b0;
        overrun_d       = 1'b0;
        acc_clear_s     = 1'b0;
        acc_en_s        = 1'b0;
        out_load_s      = 1'b0;
        if (bus.i_Sample_Start) begin
            // A start outside IDLE abandons the current sum without a result.
            overrun_d       = (state_q != ST_IDLE);
            count_d         = bus.i_Harmonic_Count;
            index_d         = '0;
            sine_flag_d     = 1'b0;
            mult_flag_d     = 1'b0;
            acc_clear_s     = 1'b1;
            busy_d          = 1'b1;
            scale_restart_d = 1'b1;
            state_d         = ST_RESTART;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RESTART: begin
                    if (count_q == '0) begin
                        out_load_s     = 1'b1;
                        sample_valid_d = 1'b1;
                        busy_d         = 1'b0;
                        state_d        = ST_DONE;
                    end else begin
                        scale_start_d = 1'b1;
                        sine_req_d    = 1'b1;
                        state_d       = ST_REQ;
                    end
                end
                ST_REQ: begin
                    sine_flag_d = 1'b0;
                    mult_flag_d = 1'b0;
                    state_d     = ST_GAP;
                end
                ST_GAP, ST_WAIT: begin
                    if (bus.i_Sine_Valid) begin
                        sine_d      = bus.i_Sine;
                        sine_flag_d = 1'b1;
                    end else begin
                        sine_flag_d = sine_flag_q;
                    end
                    // Ready is stale during GAP, so the multiple is only taken in WAIT.
                    if ((state_q == ST_WAIT) && bus.i_Mult_Ready) begin
                        mult_d      = bus.i_Mult;
                        mult_flag_d = 1'b1;
                    end else begin
                        mult_flag_d = mult_flag_q;
                    end
                    if (state_q == ST_GAP) begin
                        state_d = ST_WAIT;
                    end else if (sine_flag_d && mult_flag_d) begin
                        state_d = ST_MAC;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_MAC: begin
                    acc_en_s = 1'b1;
                    index_d  = index_q + HARM_BIT'(1);
                    if (index_d == count_q) begin
                        out_load_s     = 1'b1;
                        sample_valid_d = 1'b1;
                        busy_d         = 1'b0;
                        state_d        = ST_DONE;
                    end else begin
                        scale_start_d = 1'b1;
                        sine_req_d    = 1'b1;
                        state_d       = ST_REQ;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Sequencer state and registered handshake outputs.
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            state_q         <= ST_IDLE;
            count_q         <= '0;
            index_q         <= '0;
            sine_q          <= '0;
            mult_q          <= '0;
            sine_flag_q     <= 1'b0;
            mult_flag_q     <= 1'b0;
            scale_restart_q <= 1'b0;
            scale_start_q   <= 1'b0;
            sine_req_q      <= 1'b0;
            sample_valid_q  <= 1'b0;
            busy_q          <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            index_q         <= index_d;
            sine_q          <= sine_d;
            mult_q          <= mult_d;
            sine_flag_q     <= sine_flag_d;
            mult_flag_q     <= mult_flag_d;
            scale_restart_q <= scale_restart_d;
            scale_start_q   <= scale_start_d;
            sine_req_q      <= sine_req_d;
            sample_valid_q  <= sample_valid_d;
            busy_q          <= busy_d;
            overrun_q       <= overrun_d;
        end
    end

    harmonic_mac #(
        .DIV_BIT    (DIV_BIT),
        .SAMPLE_BIT (SAMPLE_BIT),
        .OUT_BIT    (OUT_BIT),
        .ACC_BIT    (ACC_BIT)
    ) u_mac (
        .i_Clock   (i_Clock),
        .i_Reset_N (i_Reset_N),
        .i_Clear   (acc_clear_s),
        .i_Enable  (acc_en_s),
        .i_Load    (out_load_s),
        .i_Sine    ($signed(sine_q)),
        .i_Mult    (mult_q),
        .o_Sample  (sample_s)
    );

    assign bus.o_Scale_Restart = scale_restart_q;
    assign bus.o_Scale_Start   = scale_start_q;
    assign bus.o_Sine_Req      = sine_req_q;
    assign bus.o_Harmonic      = index_q;
    assign bus.o_Sample        = sample_s;
    assign bus.o_Sample_Valid  = sample_valid_q;
    assign bus.o_Busy          = busy_q;
    assign bus.o_Overrun       = overrun_q;

endmodule

// File: tb/tb_harmonic_accumulator.sv
// Directed bench for harmonic_accumulator: a responder models the scale
// multiplier and wavetable with programmable delays; results are hand-computed.
module tb_harmonic_accumulator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    harmonic_accumulator_if hif ();

    harmonic_accumulator dut (
        .i_Clock   (clk),
        .i_Reset_N (rst_n),
        .bus       (hif)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int sine_tab [0:127];
    int mult_tab [0:127];
    int sd = 0;
    int md = 0;
    int r_scnt = 0;
    int r_mcnt = 0;
    int r_idx = 0;
    int n_start = 0;
    int n_restart = 0;
    int n_valid = 0;
    int n_overrun = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters for the DUT's one-cycle outputs.
    always @(negedge clk) begin
        if (hif.o_Scale_Start)   n_start++;
        if (hif.o_Scale_Restart) n_restart++;
        if (hif.o_Sample_Valid)  n_valid++;
        if (hif.o_Overrun)       n_overrun++;
    end

    // Responder: sine arrives sd cycles after GAP, multiple md cycles after WAIT.
    always @(negedge clk) begin
        hif.i_Sine_Valid = 1'b0;
        hif.i_Mult_Ready = 1'b0;
        if (r_scnt > 0) begin
            r_scnt--;
            if (r_scnt == 0) begin
                hif.i_Sine_Valid = 1'b1;
                hif.i_Sine = 16'(sine_tab[r_idx]);
            end
        end
        if (r_mcnt > 0) begin
            r_mcnt--;
            if (r_mcnt == 0) begin
                hif.i_Mult_Ready = 1'b1;
                hif.i_Mult = 8'(mult_tab[r_idx]);
            end
        end
        if (hif.o_Sine_Req) begin
            r_idx  = int'(hif.o_Harmonic);
            r_scnt = 1 + sd;
            r_mcnt = 2 + md;
        end
    end

    task automatic fill(input int n, input int s, input int m);
        for (int i = 0; i < 128; i++) begin
            sine_tab[i] = (i < n) ? s : 0;
            mult_tab[i] = (i < n) ? m : 0;
        end
    endtask

    task automatic run(input string tag, input int cnt, input int exp_sample,
                       input int exp_lat, input int exp_starts);
        int c, s0, r0, v0, lat, smp;
        bit got;
        @(negedge clk);
        s0 = n_start; r0 = n_restart; v0 = n_valid;
        hif.i_Sample_Start = 1'b1;
        hif.i_Harmonic_Count = 7'(cnt);
        c = cyc;
        @(negedge clk);
        hif.i_Sample_Start = 1'b0;
        got = 1'b0; lat = 0; smp = 0;
        for (int i = 0; i < 2000; i++) begin
            if (hif.o_Sample_Valid) begin
                got = 1'b1;
                lat = cyc - c;
                smp = int'($signed(hif.o_Sample));
                break;
            end
            @(negedge clk);
        end
        check_eq({tag, "_valid_seen"}, got, 1);
        check_eq({tag, "_sample"}, smp, exp_sample);
        if (exp_lat >= 0) check_eq({tag, "_latency"}, lat, exp_lat);
        @(negedge clk);
        check_eq({tag, "_scale_starts"}, n_start - s0, exp_starts);
        check_eq({tag, "_restarts"}, n_restart - r0, 1);
        check_eq({tag, "_valid_count"}, n_valid - v0, 1);
        check_eq({tag, "_busy_after"}, hif.o_Busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, o0, r0, s0;
        bit found;
        hif.i_Sample_Start = 1'b0;
        hif.i_Harmonic_Count = 7'd0;
        fill(0, 0, 0);
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", {hif.o_Scale_Restart, hif.o_Scale_Start, hif.o_Sine_Req,
                 hif.o_Harmonic, hif.o_Sample, hif.o_Sample_Valid, hif.o_Busy, hif.o_Overrun}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        fill(1, 16384, 128);
        run("single", 1, 8192, 6, 1);

        fill(3, 1000, 0);
        mult_tab[0] = 255; mult_tab[1] = 200; mult_tab[2] = 145;
        run("three", 3, 2343, 14, 3);

        fill(64, 32767, 255);
        run("sat_pos", 64, 32767, 258, 64);
        fill(64, -32768, 255);
        run("sat_neg", 64, -32768, -1, 64);

        run("zero", 0, 0, 2, 0);

        fill(3, 1000, 0);
        mult_tab[0] = 255; mult_tab[1] = 200; mult_tab[2] = 145;
        sd = 5; md = 3;
        run("delayed", 3, 2343, -1, 3);
        sd = 0; md = 0;

        fill(3, 1000, 0);
        mult_tab[0] = 255; mult_tab[1] = 0; mult_tab[2] = 145;
        run("mult_zero", 3, 1562, 14, 3);

        // Overrun: restart with count 2 while harmonic 1 of a 3-harmonic sample runs.
        fill(3, 1000, 0);
        mult_tab[0] = 255; mult_tab[1] = 200; mult_tab[2] = 145;
        @(negedge clk);
        v0 = n_valid; o0 = n_overrun; r0 = n_restart;
        hif.i_Sample_Start = 1'b1;
        hif.i_Harmonic_Count = 7'd3;
        @(negedge clk);
        hif.i_Sample_Start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (hif.o_Sine_Req && hif.o_Harmonic == 7'd1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("ovr_reached_h1", found, 1);
        check_eq("ovr_busy_before", hif.o_Busy, 1);
        run("ovr_new", 2, 1777, 10, 2);
        check_eq("ovr_overrun_pulses", n_overrun - o0, 1);
        check_eq("ovr_total_valids", n_valid - v0, 1);
        check_eq("ovr_total_restarts", n_restart - r0, 2);

        // Reset asserted while waiting for a slow multiple.
        fill(1, 1000, 100);
        md = 10;
        @(negedge clk);
        hif.i_Sample_Start = 1'b1;
        hif.i_Harmonic_Count = 7'd1;
        @(negedge clk);
        hif.i_Sample_Start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (hif.o_Sine_Req) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("rst_req_seen", found, 1);
        repeat (2) @(negedge clk);
        check_eq("rst_busy_in_wait", hif.o_Busy, 1);
        v0 = n_valid;
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_outputs_cleared", {hif.o_Scale_Restart, hif.o_Scale_Start, hif.o_Sine_Req,
                 hif.o_Harmonic, hif.o_Sample, hif.o_Sample_Valid, hif.o_Busy, hif.o_Overrun}, 0);
        repeat (2) @(negedge clk);
        md = 0;
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("rst_no_valid", n_valid - v0, 0);

        // Negative partial floors toward minus infinity.
        fill(1, -1, 1);
        run("floor_neg", 1, -1, 6, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/harmonic_accumulator.md
Name: harmonic_accumulator

Overview:
- Sums the per-harmonic partials of one output sample: partial = sine value × scaling multiple.
- Sits directly downstream of the scale multiplier and drives its restart/start handshake.
- Requests one sine value per harmonic from the wavetable lookup.
- After the last harmonic, emits one saturated signed sample to the DAC/output stage.

Parameters:
- DIV_BIT, 8: width of the unsigned multiple supplied by the scale multiplier.
- SAMPLE_BIT, 16: width of the signed sine input.
- OUT_BIT, 16: width of the signed output sample.
- HARM_BIT, 7: width of harmonic count and index (maximum 127 harmonics).
- ACC_BIT, 32: accumulator width; must be at least SAMPLE_BIT+DIV_BIT+HARM_BIT.

Ports:
- i_Clock  in  1  system clock.
- i_Reset_N  in  1  asynchronous, active-low reset.
- i_Sample_Start  in  1  one-cycle pulse that begins a new output sample.
- i_Harmonic_Count  in  HARM_BIT  number of harmonics to sum; sampled on i_Sample_Start.
- o_Scale_Restart  out  1  one-cycle pulse to the scale multiplier restart input.
- o_Scale_Start  out  1  one-cycle pulse requesting the next multiple.
- i_Mult  in  DIV_BIT  multiple from the scale multiplier; unsigned.
- i_Mult_Ready  in  1  scale multiplier ready/valid.
- o_Sine_Req  out  1  one-cycle pulse requesting the sine value for o_Harmonic.
- o_Harmonic  out  HARM_BIT  index of the harmonic being processed (0-based).
- i_Sine  in  SAMPLE_BIT  signed sine value.
- i_Sine_Valid  in  1  i_Sine qualifier; one-cycle pulse, arriving any time after o_Sine_Req.
- o_Sample  out  OUT_BIT  signed result; held until the next result.
- o_Sample_Valid  out  1  one-cycle pulse when o_Sample updates.
- o_Busy  out  1  high from accepted i_Sample_Start until DONE completes.
- o_Overrun  out  1  one-cycle pulse when i_Sample_Start arrives while busy.

Behaviour:
- Reset: all outputs 0, accumulator 0, index 0, state IDLE. Asynchronous assertion aborts any operation with no o_Sample_Valid.
- States:
  - IDLE: on i_Sample_Start, latch count, clear accumulator and index, set o_Busy, go to RESTART.
  - RESTART: o_Scale_Restart=1. Go to DONE if count==0, else to REQ.
  - REQ: o_Scale_Start=1, o_Sine_Req=1, clear both capture flags, go to GAP.
  - GAP: one idle cycle, because i_Mult_Ready is still high from the previous request. Go to WAIT.
  - WAIT: capture i_Sine on i_Sine_Valid (sets sine flag) in GAP or WAIT. Capture i_Mult on i_Mult_Ready (sets mult flag) in WAIT only. When both flags are set, go to MAC.
  - MAC: acc += sign-extended(sine) × {1'b0, mult}, then index++. Go to DONE if index+1==count, else to REQ.
  - DONE: o_Sample = saturate(acc >>> DIV_BIT) to OUT_BIT; o_Sample_Valid=1; o_Busy=0; go to IDLE.
- Arithmetic:
  - The shift is arithmetic, so results floor toward −∞.
  - Saturation clamps to +2^(OUT_BIT−1)−1 and −2^(OUT_BIT−1).
- Latency:
  - Minimum 4 cycles per harmonic (REQ, GAP, WAIT, MAC).
  - For count N≥1 with immediate inputs: 1 + 4N + 1 cycles from the cycle after i_Sample_Start to o_Sample_Valid.
  - For count 0: o_Sample_Valid occurs 2 cycles after i_Sample_Start, with o_Sample=0.
- Overrun: i_Sample_Start outside IDLE pulses o_Overrun, discards the partial sum, and restarts at RESTART with the newly latched count. No o_Sample_Valid is issued for the aborted sample.
- i_Sine_Valid outside GAP/WAIT is ignored.
- i_Mult value 0 (muted comb harmonic) is legal: its partial is 0, but index still advances.
- Simultaneous i_Sine_Valid and i_Mult_Ready in WAIT: both are captured, and MAC follows next cycle.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE, RESTART, REQ, GAP, WAIT, MAC, DONE);
  - default widths DIV_BIT, SAMPLE_BIT, OUT_BIT, HARM_BIT;
  - a saturate function.
- One sub-module: harmonic_mac. It performs the signed×unsigned multiply, accumulation, and the shift+saturate output, with clear/enable inputs. The FSM stays in the top.

Test Plan:
- count=1, sine=16384, mult=128 → o_Sample=8192; valid 6 cycles after start.
- count=3, sines 1000 each, mults 255/200/145 → acc=600000 → o_Sample=2343. o_Scale_Start must pulse exactly 3 times.
- count=64, sine=32767, mult=255 → saturates to 32767; with sine=−32768 → −32768.
- count=0 → o_Sample=0 two cycles after start; no o_Scale_Start, one o_Scale_Restart.
- Delayed handshakes:
  - i_Mult_Ready delayed 3 extra cycles and i_Sine_Valid delayed 5 → same sum as undelayed.
  - mult=0 on harmonic 1 of 3 → that partial contributes 0.
- Abort cases:
  - Second i_Sample_Start during harmonic 2 → o_Overrun pulse; the result matches a clean run using the new count.
  - i_Reset_N low mid-WAIT → all outputs 0 immediately, and no o_Sample_Valid.
